vx_csr_pipe: RTL and testbench
==============================

# vx_csr_pipe

Parametrised CSR execution pipeline for a Vortex core: arbitrates NUM_REQ requesters (core issue, debug/IO, …), executes CSRRW/CSRRS/CSRRC against per-warp scratch CSRs and read-only thread-ID CSRs, and returns per-thread results one cycle after acceptance. It sits between issue/IO and the commit stage. It also pulses `reseed` when the PRNG-reseed CSR is written.

## Interface
- NUM_REQ, 2, requester count (≥1); index 0 wins ties at reset
- NUM_WARPS, 4, warps; NW_BITS = max(1, $clog2(NUM_WARPS))
- NUM_THREADS, 4, lanes per warp
- NUM_CSRS, 8, scratch CSRs per warp at CSR_SCRATCH_BASE + 0..NUM_CSRS-1
- TAG_WIDTH, 8, opaque tag (rd/wb/PC index) passed through
- clk  in  1  clock; reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  accepted when valid & ready
- req_wid  in  NUM_REQ*NW_BITS  warp id
- req_op  in  NUM_REQ*2  00 RW, 01 RS, 10 RC, 11 illegal (read only)
- req_addr  in  NUM_REQ*12  CSR address
- req_mask  in  NUM_REQ*32  write/set/clear operand
- req_tmask  in  NUM_REQ*NUM_THREADS  thread mask
- req_tag  in  NUM_REQ*TAG_WIDTH  pass-through
- rsp_valid  out  1; rsp_ready  in  1
- rsp_sel  out  $clog2(NUM_REQ) (min 1)  requester index
- rsp_wid, rsp_tmask, rsp_tag  out  as request
- rsp_data  out  NUM_THREADS*32  per-lane old CSR value
- reseed  out  1  one-cycle pulse

## Operation
- Arbitration: round-robin; pointer moves to granted+1 on acceptance only; at most one req_ready high per cycle, and only for the granted valid requester.
- Stage S0 (comb): read old value, compute new = RW: mask; RS: old|mask; RC: old&~mask. Write intent = RW always; RS/RC only if mask≠0; never for op 11 or read-only addresses.
- Stage S1 (register): holds response; storage written in the first cycle the entry is in S1 (single write even if stalled).
- Address map: scratch range read/write; CSR_LTID → lane i; CSR_GTID → wid*NUM_THREADS+i; CSR_LWID → wid; CSR_PRNG_RESEED write-only, reads 0; all others read 0, writes dropped.
- reseed = 1 for exactly the cycle the PRNG write commits in S1 (only if write intent).
- Hazard: S0 request matching S1 entry's wid+addr with pending write: forwarded (see Configuration).

## Timing
- Latency 1: accepted at edge N, rsp_valid high from N through handshake.
- Stall: S1 valid & ~rsp_ready → all req_ready low, S1 held stable.
- Throughput 1/cycle when rsp_ready=1.
- Reset: rsp_valid=0, reseed=0, req_ready reflects empty pipe, rr pointer=0, all scratch CSRs=0, rsp_data/tag/sel=0.
- Reset mid-operation drops in-flight S1 entry; no write commits.

## Configuration
- VX_CSR_FWD_EN defined: S1 new value forwarded to S0 read; back-to-back RAW on same wid/addr at full rate.
- Undefined: hazard drops all req_ready for one cycle until S1 write commits; no forwarding mux.

## Structure
- vx_csr_pkg: op encodings, CSR_SCRATCH_BASE=12'h7C1, CSR_PRNG_RESEED=12'h7C0, CSR_LTID=12'h020, CSR_LWID=12'h021, CSR_GTID=12'h022, s1 entry struct.
- Sub-module vx_csr_rr_arb (NUM_REQ-way round-robin grant with advance-on-accept).

## Test plan
- Reset, warp0 RW scratch0 mask 0x1234 → rsp 0; next RS mask 0x00F0 same warp → rsp 0x1234; read → 0x12F4.
- Back-to-back RC mask 0x0004 then read, rsp_ready=1 → FWD_EN: 1 cycle apart, second rsp 0x12F0; without: one bubble, same data.
- Both requesters valid continuously → grants alternate 0,1,0,1; rsp_sel matches.
- GTID read wid=2, NUM_THREADS=4 → rsp_data lanes 8,9,10,11; LTID → 0,1,2,3.
- rsp_ready low 3 cycles with RW pending → S1 stable, req_ready low, storage written once; PRNG write → reseed one cycle only.
- Scratch write warp1 then read warp0 same addr → 0; RS mask 0 → no write; op 11 → no write.

Source files
------------

// File: rtl/vx_csr_pkg.sv
// rtl/vx_csr_pkg.sv - shared op encodings, CSR addresses and S1 entry type for vx_csr_pipe
package vx_csr_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RW  = 2'b00,
        CSR_OP_RS  = 2'b01,
        CSR_OP_RC  = 2'b10,
        CSR_OP_ILL = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_PRNG_RESEED  = 12'h7C0;
    localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C1;
    localparam logic [11:0] CSR_LTID         = 12'h020;
    localparam logic [11:0] CSR_LWID         = 12'h021;
    localparam logic [11:0] CSR_GTID         = 12'h022;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] new_val;
        logic        wr_pend;
    } s1_entry_t;

    function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old_val,
                                              input logic [31:0] mask);
        case (op)
            CSR_OP_RW: return mask;
            CSR_OP_RS: return old_val | mask;
            CSR_OP_RC: return old_val & ~mask;
            default:   return old_val;
        endcase
    endfunction

    // RS/RC with an empty operand are pure reads and must not claim the write port.
    function automatic logic csr_op_writes(input csr_op_e op, input logic [31:0] mask);
        case (op)
            CSR_OP_RW: return 1'b1;
            CSR_OP_RS,
            CSR_OP_RC: return (mask != 32'd0);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vx_csr_rr_arb.sv
// rtl/vx_csr_rr_arb.sv - round-robin grant across NUM_REQ requesters, pointer advances only on acceptance
module vx_csr_rr_arb #(
    parameter  int NUM_REQ = 2,
    localparam int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] ready_o,
    output logic [SEL_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                idx   = SEL_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign grant_idx_o   = idx;
    assign grant_valid_o = found;

    always_comb begin
        ready_o = '0;
        if (found && enable_i) ready_o[idx] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found && enable_i) ptr_d = SEL_W'((int'(idx) + 1) % NUM_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vx_csr_pipe.sv
// rtl/vx_csr_pipe.sv - two-stage CSR execute pipe; VX_CSR_FWD_EN enables S1->S0 forwarding instead of RAW stall
module vx_csr_pipe
    import vx_csr_pkg::*;
#(
    parameter  int NUM_REQ     = 2,
    parameter  int NUM_WARPS   = 4,
    parameter  int NUM_THREADS = 4,
    parameter  int NUM_CSRS    = 8,
    parameter  int TAG_WIDTH   = 8,
    localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int SEL_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*NW_BITS-1:0]     req_wid,
    input  logic [NUM_REQ*2-1:0]           req_op,
    input  logic [NUM_REQ*12-1:0]          req_addr,
    input  logic [NUM_REQ*32-1:0]          req_mask,
    input  logic [NUM_REQ*NUM_THREADS-1:0] req_tmask,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [SEL_W-1:0]               rsp_sel,
    output logic [NW_BITS-1:0]             rsp_wid,
    output logic [NUM_THREADS-1:0]         rsp_tmask,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    output logic [NUM_THREADS*32-1:0]      rsp_data,
    output logic                           reseed
);

    localparam int CI_W = (NUM_CSRS > 1) ? $clog2(NUM_CSRS) : 1;

    logic [31:0] scratch_q [NUM_WARPS][NUM_CSRS];

    s1_entry_t                  s1_q, s1_d;
    logic                       s1_valid_q, s1_valid_d;
    logic [SEL_W-1:0]           s1_sel_q, s1_sel_d;
    logic [NW_BITS-1:0]         s1_wid_q, s1_wid_d;
    logic [NUM_THREADS-1:0]     s1_tmask_q, s1_tmask_d;
    logic [TAG_WIDTH-1:0]       s1_tag_q, s1_tag_d;
    logic [NUM_THREADS*32-1:0]  s1_data_q, s1_data_d;

    logic [SEL_W-1:0]           gidx;
    logic                       gvalid, enable, accept, stall, hazard;

    vx_csr_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk           (clk),
        .rst           (reset),
        .valid_i       (req_valid),
        .enable_i      (enable),
        .ready_o       (req_ready),
        .grant_idx_o   (gidx),
        .grant_valid_o (gvalid)
    );

    logic [NW_BITS-1:0]        s0_wid;
    csr_op_e                   s0_op;
    logic [11:0]               s0_addr;
    logic [31:0]               s0_mask;
    logic [NUM_THREADS-1:0]    s0_tmask;
    logic [TAG_WIDTH-1:0]      s0_tag;
    logic                      s0_is_scratch, s0_match, s0_wr;
    logic [CI_W-1:0]           s0_cidx;
    logic [31:0]               s0_scratch, s0_old, s0_new;
    logic [NUM_THREADS*32-1:0] s0_data;

    assign s0_wid   = req_wid[int'(gidx)*NW_BITS +: NW_BITS];
    assign s0_op    = csr_op_e'(req_op[int'(gidx)*2 +: 2]);
    assign s0_addr  = req_addr[int'(gidx)*12 +: 12];
    assign s0_mask  = req_mask[int'(gidx)*32 +: 32];
    assign s0_tmask = req_tmask[int'(gidx)*NUM_THREADS +: NUM_THREADS];
    assign s0_tag   = req_tag[int'(gidx)*TAG_WIDTH +: TAG_WIDTH];

    assign s0_is_scratch = (s0_addr >= CSR_SCRATCH_BASE) &&
                           (s0_addr < CSR_SCRATCH_BASE + 12'(NUM_CSRS));
    assign s0_cidx  = CI_W'(s0_addr - CSR_SCRATCH_BASE);
    assign s0_match = s1_valid_q && s1_q.wr_pend && (s1_wid_q == s0_wid) && (s1_q.addr == s0_addr);

`ifdef VX_CSR_FWD_EN
    assign s0_scratch = s0_match ? s1_q.new_val : scratch_q[s0_wid][s0_cidx];
    assign hazard     = 1'b0;
`else
    // Storage catches up at the end of the entry's first S1 cycle, so a one-cycle hold suffices.
    assign s0_scratch = scratch_q[s0_wid][s0_cidx];
    assign hazard     = gvalid && s0_match;
`endif

    assign s0_old = s0_is_scratch ? s0_scratch : 32'd0;
    assign s0_new = csr_apply(s0_op, s0_old, s0_mask);
    assign s0_wr  = csr_op_writes(s0_op, s0_mask) &&
                    (s0_is_scratch || (s0_addr == CSR_PRNG_RESEED));

    always_comb begin
        s0_data = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (s0_is_scratch)              s0_data[i*32 +: 32] = s0_scratch;
            else if (s0_addr == CSR_LTID)   s0_data[i*32 +: 32] = 32'(i);
            else if (s0_addr == CSR_GTID)   s0_data[i*32 +: 32] = 32'(int'(s0_wid) * NUM_THREADS + i);
            else if (s0_addr == CSR_LWID)   s0_data[i*32 +: 32] = 32'(s0_wid);
            else                            s0_data[i*32 +: 32] = 32'd0;
        end
    end

    assign stall  = s1_valid_q && !rsp_ready;
    assign enable = !stall && !hazard;
    assign accept = gvalid && enable;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_d         = s1_q;
        s1_d.wr_pend = 1'b0;
        s1_sel_d     = s1_sel_q;
        s1_wid_d     = s1_wid_q;
        s1_tmask_d   = s1_tmask_q;
        s1_tag_d     = s1_tag_q;
        s1_data_d    = s1_data_q;
        if (accept) begin
            s1_valid_d   = 1'b1;
            s1_d.addr    = s0_addr;
            s1_d.new_val = s0_new;
            s1_d.wr_pend = s0_wr;
            s1_sel_d     = gidx;
            s1_wid_d     = s0_wid;
            s1_tmask_d   = s0_tmask;
            s1_tag_d     = s0_tag;
            s1_data_d    = s0_data;
        end else if (rsp_ready) begin
            s1_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_sel_q   <= '0;
            s1_wid_q   <= '0;
            s1_tmask_q <= '0;
            s1_tag_q   <= '0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s1_sel_q   <= s1_sel_d;
            s1_wid_q   <= s1_wid_d;
            s1_tmask_q <= s1_tmask_d;
            s1_tag_q   <= s1_tag_d;
            s1_data_q  <= s1_data_d;
        end
    end

    logic            s1_commit, s1_is_scratch;
    logic [CI_W-1:0] s1_cidx;

    assign s1_commit     = s1_valid_q && s1_q.wr_pend;
    assign s1_is_scratch = (s1_q.addr >= CSR_SCRATCH_BASE) &&
                           (s1_q.addr < CSR_SCRATCH_BASE + 12'(NUM_CSRS));
    assign s1_cidx       = CI_W'(s1_q.addr - CSR_SCRATCH_BASE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++)
                for (int c = 0; c < NUM_CSRS; c++)
                    scratch_q[w][c] <= 32'd0;
        end else if (s1_commit && s1_is_scratch) begin
            scratch_q[s1_wid_q][s1_cidx] <= s1_q.new_val;
        end
    end

    assign rsp_valid = s1_valid_q;
    assign rsp_sel   = s1_sel_q;
    assign rsp_wid   = s1_wid_q;
    assign rsp_tmask = s1_tmask_q;
    assign rsp_tag   = s1_tag_q;
    assign rsp_data  = s1_data_q;
    assign reseed    = s1_commit && (s1_q.addr == CSR_PRNG_RESEED);

endmodule

// File: tb/tb_vx_csr_pipe.sv
// tb/tb_vx_csr_pipe.sv - scoreboard bench for vx_csr_pipe with directed vectors
module tb_vx_csr_pipe;

    localparam int NR = 2;
    localparam int NT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*2-1:0]  req_wid;
    logic [NR*2-1:0]  req_op;
    logic [NR*12-1:0] req_addr;
    logic [NR*32-1:0] req_mask;
    logic [NR*NT-1:0] req_tmask;
    logic [NR*8-1:0]  req_tag;
    logic             rsp_valid, rsp_ready;
    logic [0:0]       rsp_sel;
    logic [1:0]       rsp_wid;
    logic [NT-1:0]    rsp_tmask;
    logic [7:0]       rsp_tag;
    logic [NT*32-1:0] rsp_data;
    logic             reseed;

    vx_csr_pipe dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid), .req_op(req_op),
        .req_addr(req_addr), .req_mask(req_mask), .req_tmask(req_tmask), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sel(rsp_sel), .rsp_wid(rsp_wid),
        .rsp_tmask(rsp_tmask), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .reseed(reseed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:0]   sel;
        logic [1:0]   wid;
        logic [3:0]   tmask;
        logic [7:0]   tag;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   reseed_cnt = 0;
    logic [7:0] tag_ctr = 8'h10;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (reseed) reseed_cnt++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] rep(input logic [31:0] v);
        return {v, v, v, v};
    endfunction

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {120'd0, rsp_tag}, 128'd0 - 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_sel", rsp_sel, e.sel);
                chk("rsp_wid", rsp_wid, e.wid);
                chk("rsp_tmask", rsp_tmask, e.tmask);
                chk("rsp_tag", rsp_tag, e.tag);
                chk("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic issue(input int r, input logic [1:0] wid, input logic [1:0] op,
                         input logic [11:0] addr, input logic [31:0] mask,
                         input logic [3:0] tmask, input logic [127:0] exp_data);
        int  n;
        bit  ok;
        exp_t e;
        n  = 0;
        ok = 1'b0;
        req_valid[r]          = 1'b1;
        req_wid[r*2 +: 2]     = wid;
        req_op[r*2 +: 2]      = op;
        req_addr[r*12 +: 12]  = addr;
        req_mask[r*32 +: 32]  = mask;
        req_tmask[r*NT +: NT] = tmask;
        req_tag[r*8 +: 8]     = tag_ctr;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (req_ready[r]) ok = 1'b1;
            else n++;
        end
        if (ok) begin
            e.sel = 1'(r); e.wid = wid; e.tmask = tmask; e.tag = tag_ctr; e.data = exp_data;
            exp_q.push_back(e);
            acc_cyc = cyc;
        end else begin
            chk("accept_timeout", {120'd0, tag_ctr}, 128'd0 - 1);
        end
        tag_ctr = tag_ctr + 8'd1;
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int a1, a2, a3, r0, g, n;
        reset = 1'b1; rsp_ready = 1'b1; req_valid = '0; req_wid = '0; req_op = '0;
        req_addr = '0; req_mask = '0; req_tmask = '0; req_tag = '0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_reseed", reseed, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_tag", rsp_tag, 0);
        chk("reset_rsp_sel", rsp_sel, 0);
        chk("reset_req_ready_idle", req_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(0, 2'd0, 2'b00, 12'h7C1, 32'h1234, 4'hF, rep(32'h0));
        issue(0, 2'd0, 2'b01, 12'h7C1, 32'h00F0, 4'hF, rep(32'h1234));
        issue(0, 2'd0, 2'b01, 12'h7C1, 32'h0,    4'h3, rep(32'h12F4));
        issue(0, 2'd0, 2'b10, 12'h7C1, 32'h0004, 4'hF, rep(32'h12F4));
        a1 = acc_cyc;
        issue(0, 2'd0, 2'b01, 12'h7C1, 32'h0,    4'hF, rep(32'h12F0));
        a2 = acc_cyc;
`ifdef VX_CSR_FWD_EN
        chk("raw_gap_cycles", 128'(a2 - a1), 1);
`else
        chk("raw_gap_cycles", 128'(a2 - a1), 2);
`endif
        issue(0, 2'd0, 2'b01, 12'h7C1, 32'h0,    4'hF, rep(32'h12F0));
        a3 = acc_cyc;
        chk("read_read_gap_cycles", 128'(a3 - a2), 1);

        issue(0, 2'd2, 2'b11, 12'h022, 32'h0,    4'hF, {32'd11, 32'd10, 32'd9, 32'd8});
        issue(0, 2'd2, 2'b00, 12'h020, 32'hFFFF, 4'h5, {32'd3, 32'd2, 32'd1, 32'd0});
        issue(0, 2'd2, 2'b11, 12'h020, 32'h0,    4'hF, {32'd3, 32'd2, 32'd1, 32'd0});
        issue(0, 2'd1, 2'b00, 12'h7C3, 32'h55,   4'hF, rep(32'h0));
        issue(0, 2'd0, 2'b01, 12'h7C3, 32'h0,    4'hF, rep(32'h0));
        issue(0, 2'd1, 2'b11, 12'h7C3, 32'hFF,   4'hF, rep(32'h55));
        issue(0, 2'd1, 2'b01, 12'h7C3, 32'h0,    4'hF, rep(32'h55));
        issue(0, 2'd3, 2'b00, 12'h100, 32'h9,    4'hF, rep(32'h0));
        issue(0, 2'd3, 2'b01, 12'h100, 32'h0,    4'hF, rep(32'h0));

        repeat (2) @(posedge clk);
        #1 rsp_ready = 1'b0;
        r0 = reseed_cnt;
        issue(0, 2'd0, 2'b00, 12'h7C0, 32'h5, 4'hF, rep(32'h0));
        req_valid[1] = 1'b1; req_wid[3:2] = 2'd1; req_op[3:2] = 2'b11;
        req_addr[23:12] = 12'h020; req_tag[15:8] = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_data", rsp_data, 0);
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk);
        #1 req_valid[1] = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("reseed_pulses", 128'(reseed_cnt - r0), 1);
        issue(0, 2'd0, 2'b01, 12'h7C0, 32'h0, 4'hF, rep(32'h0));

        req_valid = 2'b11;
        req_wid = {2'd2, 2'd1}; req_op = {2'b11, 2'b11}; req_addr = {12'h021, 12'h021};
        req_tmask = {4'h9, 4'h6}; req_tag = {8'h41, 8'h40};
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            @(negedge clk);
            chk("arb_onehot", 128'($countones(req_ready)), 1);
            g = req_ready[1] ? 1 : 0;
            chk("arb_grant", 128'(g), (k % 2 == 0) ? 128'd1 : 128'd0);
            e.sel = 1'(g); e.wid = g ? 2'd2 : 2'd1; e.tmask = g ? 4'h9 : 4'h6;
            e.tag = g ? 8'h41 : 8'h40; e.data = rep(g ? 32'd2 : 32'd1);
            exp_q.push_back(e);
            @(posedge clk);
        end
        #1 req_valid = '0;

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1 chk("scoreboard_drained", 128'(exp_q.size()), 0);
        chk("reseed_total", 128'(reseed_cnt), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
